// File: rtl/pow_seq_ctrl_if.sv
// ============================================================================
// Module      : pow_seq_ctrl_if
// Description : Host/datapath-facing bundle of the power-sequence controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pow_seq_ctrl_if #(
  parameter int K_W = 4
);
  logic           start;
  logic [K_W-1:0] k;
  logic           ovf;
  logic           ready;
  logic           x_ld;
  logic           acc_sset;
  logic           acc_sclr;
  logic           acc_ld;
  logic [K_W-1:0] iter;
  logic           done;
  logic           err;

  // master = host + datapath side, slave = the controller
  modport master (
    output start, k, ovf,
    input  ready, x_ld, acc_sset, acc_sclr, acc_ld, iter, done, err
  );

  modport slave (
    input  start, k, ovf,
    output ready, x_ld, acc_sset, acc_sclr, acc_ld, iter, done, err
  );
endinterface

`default_nettype wire

// File: rtl/pow_seq_ctrl.sv
// ============================================================================
// Module      : pow_seq_ctrl
// Description : Control FSM sequencing y = x^k on a Q8.8 multiply/accumulate path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pow_seq_ctrl #(
  parameter int K_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  pow_seq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0] iter_q, iter_d;
  logic           err_q, err_d;

  logic           ready_w;
  logic           x_ld_w;
  logic           acc_sset_w;
  logic           acc_sclr_w;
  logic           acc_ld_w;
  logic           done_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iter_d     = iter_q;
    err_d      = err_q;
    ready_w    = 1'b0;
    x_ld_w     = 1'b0;
    acc_sset_w = 1'b0;
    acc_sclr_w = 1'b0;
    acc_ld_w   = 1'b0;
    done_w     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_w = 1'b1;
        if (bus.start) begin
          cnt_d   = bus.k;
          iter_d  = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        x_ld_w     = 1'b1;
        acc_sset_w = 1'b1;
        state_d    = (cnt_q == '0) ? ST_FIN : ST_MUL;
      end
      ST_MUL: begin
        // Accumulator strobes are suppressed under reset so an aborted run
        // leaves the accumulator holding its last completed product.
        if (bus.ovf) begin
          acc_sclr_w = !rst;
          err_d      = 1'b1;
          state_d    = ST_FIN;
        end else begin
          acc_ld_w = !rst;
          cnt_d    = cnt_q - K_W'(1);
          iter_d   = iter_q + K_W'(1);
          if (cnt_q == K_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        done_w  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ready    = ready_w;
  assign bus.x_ld     = x_ld_w;
  assign bus.acc_sset = acc_sset_w;
  assign bus.acc_sclr = acc_sclr_w;
  assign bus.acc_ld   = acc_ld_w;
  assign bus.done     = done_w;
  assign bus.iter     = iter_q;
  assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pow_seq_ctrl.sv
// ============================================================================
// Module      : tb_pow_seq_ctrl
// Description : Self-checking bench with a Q8.8 accumulator/multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pow_seq_ctrl;

  localparam int K_W = 4;

  logic        clk;
  logic        rst;
  logic [15:0] x_in;
  logic [15:0] x_reg;
  logic [15:0] acc;
  logic [31:0] prod_full;

  int checks;
  int errors;

  pow_seq_ctrl_if #(.K_W(K_W)) bus ();

  pow_seq_ctrl #(.K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath environment: operand register, accumulator, Q8.8 multiplier
  assign prod_full = (32'(acc) * 32'(x_reg)) >> 8;
  assign bus.ovf   = (prod_full >= 32'h0000_8000);

  always_ff @(posedge clk) begin
    if (bus.x_ld) x_reg <= x_in;
    if (bus.acc_sset)      acc <= 16'h0100;
    else if (bus.acc_sclr) acc <= 16'h0000;
    else if (bus.acc_ld)   acc <= prod_full[15:0];
  end

  typedef struct {
    logic [15:0] x;
    logic [3:0]  k;
    logic [15:0] acc;
    int          iter;
    bit          err;
    int          done_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: straight-line power loop over unsigned Q8.8 values
  task automatic ref_pow(input logic [15:0] x, input int k,
                         output logic [15:0] racc, output int n, output bit rerr);
    longint a;
    longint p;
    a = 64'h100; n = 0; rerr = 1'b0;
    for (int i = 0; i < k; i++) begin
      p = (a * longint'(x)) / 256;
      if (p >= 64'h8000) begin
        rerr = 1'b1; a = 0;
        break;
      end
      a = p; n++;
    end
    racc = a[15:0];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [15:0] x, input logic [3:0] kk);
    int n;
    n = 0;
    while (!bus.ready && n < 50) begin
      tick(); n++;
    end
    chk("accept_ready", bus.ready, 1);
    x_in = x; bus.k = kk; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.k = $urandom_range(0, 15);
  endtask

  // Called in cycle 1 (LOAD); returns in the done cycle
  task automatic monitor(input bit busy_start, output int done_cyc,
                         output int n_ld, output int n_sclr, output int n_sset);
    int cyc;
    cyc = 1; n_ld = 0; n_sclr = 0; n_sset = 0; done_cyc = -1;
    while (cyc < 40) begin
      if (bus.acc_ld && bus.acc_sclr) chk("ld_sclr_excl", 1, 0);
      if (bus.acc_sset && cyc != 1)   chk("sset_outside_load", cyc, 1);
      n_ld   += int'(bus.acc_ld);
      n_sclr += int'(bus.acc_sclr);
      n_sset += int'(bus.acc_sset);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (busy_start && cyc == 3) begin bus.start = 1'b1; bus.k = 4'd2; end
      if (busy_start && cyc == 4) bus.start = 1'b0;
      tick(); cyc++;
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input string nm, input logic [15:0] x, input logic [3:0] kk,
                         input logic [15:0] e_acc, input int e_iter, input bit e_err,
                         input int e_done, input bit busy_start);
    int dc, nl, ns, nss;
    accept(x, kk);
    monitor(busy_start, dc, nl, ns, nss);
    chk({nm, "_done_cyc"}, dc, e_done);
    chk({nm, "_acc"}, acc, e_acc);
    chk({nm, "_iter"}, bus.iter, e_iter);
    chk({nm, "_err"}, bus.err, e_err);
    chk({nm, "_n_ld"}, nl, e_iter);
    chk({nm, "_n_sclr"}, ns, int'(e_err));
    chk({nm, "_n_sset"}, nss, 1);
    tick();
    chk({nm, "_ready_after"}, bus.ready, 1);
    chk({nm, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    logic [15:0] racc;
    int          rn;
    bit          rerr;
    int          dcount;

    checks = 0; errors = 0;
    bus.start = 1'b0; bus.k = '0; x_in = 16'h0100; rst = 1'b1;

    vecs[0] = '{16'h0180, 4'd3,  16'h0360, 3,  1'b0, 5};
    vecs[1] = '{16'h0500, 4'd0,  16'h0100, 0,  1'b0, 2};
    vecs[2] = '{16'h1000, 4'd4,  16'h0000, 1,  1'b1, 4};
    vecs[3] = '{16'h0100, 4'd2,  16'h0100, 2,  1'b0, 4};
    vecs[4] = '{16'h0100, 4'd15, 16'h0100, 15, 1'b0, 17};
    vecs[5] = '{16'h0080, 4'd1,  16'h0080, 1,  1'b0, 3};
    vecs[6] = '{16'h0200, 4'd7,  16'h0000, 6,  1'b1, 9};
    vecs[7] = '{16'h0200, 4'd6,  16'h4000, 6,  1'b0, 8};

    tick(); tick();
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_iter", bus.iter, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ctrl", {bus.x_ld, bus.acc_sset, bus.acc_ld, bus.acc_sclr}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].k, vecs[i].acc,
              vecs[i].iter, vecs[i].err, vecs[i].done_cyc, 1'b0);
    end

    // Start while busy is ignored; next run starts in the first ready cycle
    run_vec("busy_run1", 16'h0100, 4'd5, 16'h0100, 5, 1'b0, 7, 1'b1);
    run_vec("b2b_run2",  16'h0180, 4'd2, 16'h0240, 2, 1'b0, 4, 1'b0);

    // Reset in the 3rd MUL cycle aborts the run and keeps the accumulator
    accept(16'h0140, 4'd6);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_iter", bus.iter, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_acc", acc, 16'h0190);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      dcount += int'(bus.done);
      tick();
    end
    chk("midrst_no_done", dcount, 0);
    run_vec("after_rst", 16'h0180, 4'd3, 16'h0360, 3, 1'b0, 5, 1'b0);

    // Reset coincident with start: the start is lost
    rst = 1'b1; bus.start = 1'b1; bus.k = 4'd3;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    tick();
    chk("rst_start_idle", bus.ready, 1);
    chk("rst_start_no_xld", bus.x_ld, 0);

    // Randomized runs against the reference loop
    for (int r = 0; r < 30; r++) begin
      logic [15:0] rx;
      logic [3:0]  rk;
      rx = 16'($urandom_range(16'h0080, 16'h0300));
      rk = 4'($urandom_range(0, 15));
      ref_pow(rx, int'(rk), racc, rn, rerr);
      repeat ($urandom_range(0, 2)) tick();
      run_vec($sformatf("rnd%0d", r), rx, rk, racc, rn, rerr,
              rerr ? rn + 3 : int'(rk) + 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pow_seq_ctrl.md
Name: pow_seq_ctrl

Overview:
- Control FSM for the Q8.8 power datapath, which computes y = x^k by repeated multiplication into a 16-bit accumulator register.
- Drives the operand-register load and the accumulator's load / sync-clear / sync-set-to-1.0 (0x0100) controls.
- Counts iterations, handles multiplier overflow, and reports completion to the host through a start/ready/done handshake.
- Pure control block: no datapath bits pass through it.

Parameters:
- K_W, 4, width of the exponent input and the internal iteration counter; maximum exponent is 2^K_W-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- k  input  K_W  exponent; captured on the cycle start is accepted.
- ovf  input  1  multiplier overflow flag from the datapath, valid combinationally in the same cycle.
- ready  output  1  high in IDLE only.
- x_ld  output  1  load the operand register with x.
- acc_sset  output  1  accumulator synchronous set to 0x0100 (1.0).
- acc_sclr  output  1  accumulator synchronous clear.
- acc_ld  output  1  accumulator load of (acc * x).
- iter  output  K_W  number of multiplies completed in the current run.
- done  output  1  one-cycle completion pulse.
- err  output  1  overflow status of the last run; held until the next accepted start.

Behaviour:
- Reset is synchronous, active-high and has priority over everything. On reset:
  - state=IDLE; iter=0; err=0; internal count=0.
  - ready=1; all other control outputs 0.
  - Reset mid-run aborts immediately. No done pulse is issued, and the accumulator is left untouched.
- States:
  - IDLE: ready=1. If start: capture k into the count, clear iter and err, go to LOAD. Otherwise stay.
  - LOAD: exactly 1 cycle. Assert x_ld=1 and acc_sset=1. If the count==0, go to FIN. Else go to MUL.
  - MUL, ovf=0: assert acc_ld=1, decrement the count, increment iter. Go to FIN when the count was 1 this cycle; otherwise stay.
  - MUL, ovf=1: assert acc_sclr=1 and acc_ld=0. Set err=1, leave iter unchanged, go to FIN.
  - FIN: done=1 for exactly 1 cycle, then go to IDLE.
- Output decode:
  - ready, x_ld, acc_sset and done are Moore outputs (decoded from state only).
  - acc_ld and acc_sclr are Mealy outputs in MUL (they depend on ovf).
  - acc_sclr and acc_ld are never high in the same cycle.
  - acc_sset is never high outside LOAD.
- Latency, with start accepted at edge 0:
  - LOAD occupies cycle 1.
  - MUL occupies cycles 2..k+1.
  - done is high in cycle k+2.
  - k=0 gives done in cycle 2 with the accumulator = 0x0100.
  - ready returns in cycle k+3.
  - Back-to-back: a start in that first ready cycle is accepted.
- Handshake:
  - start outside IDLE is ignored, with no queuing.
  - k is sampled only at acceptance; later changes to k have no effect on the run.
  - start held high continuously re-triggers a new run each time IDLE is reached.
- Width rules:
  - iter and the count are K_W bits; k=2^K_W-1 runs the full range.
  - iter never wraps within a run.
- Simultaneous events:
  - ovf on the final multiply takes the error path (sclr, err=1), not a normal finish.
  - rst together with start resets; the start is lost.
- err reads 0 during a run until an overflow occurs, and is valid from the done cycle onward.

Test Plan:
- Bench setup: the accumulator register plus a Q8.8 multiplier model that saturates its ovf flag at >= 0x8000 result.
- Reset then idle: rst=1 for 2 cycles -> ready=1, done=0, iter=0, err=0, x_ld=acc_sset=acc_ld=acc_sclr=0.
- Nominal run: x=0x0180 (1.5), k=3, start pulse at edge 0 -> acc_sset in cycle 1; acc_ld high in cycles 2-4; done in cycle 5; acc=0x0360 (3.375); iter=3; err=0.
- Zero exponent: x=0x0500, k=0 -> no acc_ld ever; done in cycle 2; acc=0x0100; iter=0.
- Overflow: x=0x1000 (16.0), k=4 -> ovf on the 2nd multiply; acc_sclr asserted that cycle; done next cycle; acc=0x0000; err=1; iter=1. A following run with x=0x0100, k=2 clears err -> acc=0x0100, err=0.
- Start during busy plus back-to-back:
  - Run 1: k=5. Assert start again in MUL with k=2 -> ignored; iter reaches 5.
  - Run 2: start in the first ready cycle with k=2 -> accepted; done exactly 4 cycles later.
- Reset mid-run: k=6, rst in the 3rd MUL cycle -> next cycle state IDLE, ready=1, iter=0, no done pulse; a subsequent run completes normally.
